// File: rtl/miriscv_apb_bridge.sv
// miriscv_apb_bridge
// Core data-port (req/gnt/rvalid) to APB4 bridge. One request in flight at a
// time: the request is captured on grant, the slave is decoded from an address
// field, and a SETUP/ACCESS transfer is run honouring PREADY and PSLVERR.
// Completion is a single-cycle rvalid pulse for both reads and writes.
// Optional feature macro: MIRISCV_APB_TIMEOUT_EN adds an ACCESS-phase
// watchdog that ends a stuck transfer with an error after TIMEOUT_CYCLES.
`timescale 1ns/1ps
module miriscv_apb_bridge #(
  parameter int NUM_SLAVES     = 2,
  parameter int SLAVE_SEL_LSB  = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  // core data port
  input  logic                     data_req_i,
  input  logic                     data_we_i,
  input  logic [3:0]               data_be_i,
  input  logic [31:0]              data_addr_i,
  input  logic [31:0]              data_wdata_i,
  output logic                     data_gnt_o,
  output logic                     data_rvalid_o,
  output logic [31:0]              data_rdata_o,
  output logic                     data_err_o,
  // APB master
  output logic [31:0]              paddr_o,
  output logic                     pwrite_o,
  output logic [31:0]              pwdata_o,
  output logic [3:0]               pstrb_o,
  output logic [NUM_SLAVES-1:0]    psel_o,
  output logic                     penable_o,
  input  logic [32*NUM_SLAVES-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]    pready_i,
  input  logic [NUM_SLAVES-1:0]    pslverr_i
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // one extra bit so idx values at or beyond NUM_SLAVES compare correctly
  localparam logic [SEL_W:0] NS_L = (SEL_W+1)'(NUM_SLAVES);

  // elaboration-time parameter sanity
  if (NUM_SLAVES < 1) begin : g_bad_ns
    $error("miriscv_apb_bridge: NUM_SLAVES must be >= 1");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_to
    $error("miriscv_apb_bridge: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // captured core request; every APB output is driven from here
  typedef struct packed {
    logic [31:0]      addr;
    logic             we;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [SEL_W-1:0] idx;
  } apb_req_t;

  state_e           state_q, state_d;
  apb_req_t         req_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [SEL_W-1:0] idx_in;
  logic             dec_err;
  logic             apb_act;
  logic [31:0]      sel_rdata;
  logic             sel_ready;
  logic             sel_err;
  logic             to_hit;

  assign idx_in  = data_addr_i[SLAVE_SEL_LSB +: SEL_W];
  assign dec_err = ({1'b0, idx_in} >= NS_L);
  assign apb_act = (state_q == SETUP) || (state_q == ACCESS);

  // pick response signals of the selected slave only; the rest are ignored
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (req_q.idx == SEL_W'(k)) begin
        sel_rdata = prdata_i[32*k +: 32];
        sel_ready = pready_i[k];
        sel_err   = pslverr_i[k];
      end
    end
  end

`ifdef MIRISCV_APB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] to_cnt_q;

  // fires on the ACCESS cycle where the low-pready count reaches the limit;
  // a pready arriving on that same cycle takes priority
  assign to_hit = (state_q == ACCESS) && !sel_ready && (to_cnt_q == (TO_LIM - 8'd1));

  // count ACCESS cycles spent waiting; cleared while in SETUP (entry to ACCESS)
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)                              to_cnt_q <= '0;
    else if (state_q == SETUP)                 to_cnt_q <= '0;
    else if ((state_q == ACCESS) && !sel_ready) to_cnt_q <= to_cnt_q + 8'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state and grant
  always_comb begin
    state_d    = state_q;
    data_gnt_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          data_gnt_o = 1'b1;
          state_d    = dec_err ? RESP : SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (sel_ready || to_hit) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture request on grant; capture response at end of ACCESS or on decode error
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (data_gnt_o) begin
        req_q.addr  <= data_addr_i;
        req_q.we    <= data_we_i;
        req_q.be    <= data_be_i;
        req_q.wdata <= data_wdata_i;
        req_q.idx   <= idx_in;
        if (dec_err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == ACCESS) begin
        if (sel_ready) begin
          rdata_q <= req_q.we ? 32'h0 : sel_rdata;
          err_q   <= sel_err;
        end else if (to_hit) begin
          rdata_q <= 32'hDEAD_BEEF;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // one-hot select, only during SETUP/ACCESS; drops with async reset via state_q
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_psel
    assign psel_o[k] = apb_act && (req_q.idx == SEL_W'(k));
  end

  assign penable_o     = (state_q == ACCESS);
  assign paddr_o       = req_q.addr;
  assign pwrite_o      = req_q.we;
  assign pwdata_o      = req_q.wdata;
  assign pstrb_o       = req_q.we ? req_q.be : 4'b0000;

  assign data_rvalid_o = (state_q == RESP);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// Bench for miriscv_apb_bridge: directed scenarios plus randomized transfers
// against a word-memory model of three APB slaves and a decode-error hole.
`timescale 1ns/1ps
module tb_miriscv_apb_bridge;

  localparam int NS  = 3;
  localparam int LSB = 12;
  localparam int TO  = 8;

  logic              clk_i = 1'b0;
  logic              arstn_i;
  logic              data_req_i, data_we_i;
  logic [3:0]        data_be_i;
  logic [31:0]       data_addr_i, data_wdata_i;
  logic              data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]       data_rdata_o;
  logic [31:0]       paddr_o, pwdata_o;
  logic              pwrite_o, penable_o;
  logic [3:0]        pstrb_o;
  logic [NS-1:0]     psel_o;
  logic [32*NS-1:0]  prdata_i;
  logic [NS-1:0]     pready_i, pslverr_i;

  int checks = 0;
  int errors = 0;

  // slave memory model: 3 slaves x 16 words
  logic [31:0] mem [0:NS-1][0:15];

  always #5 clk_i = ~clk_i;

  miriscv_apb_bridge #(.NUM_SLAVES(NS), .SLAVE_SEL_LSB(LSB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run one core request and act as the APB slaves. Cycle 0 is the request cycle.
  // waits = ACCESS cycles with pready low before the selected slave is ready.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input int waits, input logic serr,
                        input logic cont, input logic keep, input int max_cyc,
                        output logic got, output int lat, output logic [31:0] rd,
                        output logic er);
    int k, w, acc;
    logic dec;
    logic [31:0] oh;
    k   = int'(addr[LSB +: 2]);
    w   = int'(addr[5:2]);
    dec = (k >= NS);
    oh  = dec ? 32'h0 : (32'h1 << k);
    got = 1'b0; lat = -1; rd = '0; er = 1'b0; acc = 0;
    if (!cont) begin
      @(posedge clk_i); #1;
    end
    data_req_i = 1'b1; data_addr_i = addr; data_we_i = we;
    data_be_i = be; data_wdata_i = wd;
    pready_i = NS'($urandom); pslverr_i = NS'($urandom);
    for (int j = 0; j < NS; j++)
      prdata_i[32*j +: 32] = (j == k) ? mem[j][w] : $urandom;
    if (!dec) pready_i[k] = 1'b0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk_i);
      chk($sformatf("gnt_c%0d", c), {31'b0, data_gnt_o}, {31'b0, c == 0});
      if (data_rvalid_o) begin
        got = 1'b1; lat = c; rd = data_rdata_o; er = data_err_o;
        chk("resp_psel_idle", 32'(psel_o), 32'h0);
        chk("resp_penable_idle", {31'b0, penable_o}, 32'h0);
        if (!keep) data_req_i = 1'b0;
      end else if (c >= 1) begin
        chk("psel", 32'(psel_o), oh);
        chk("penable", {31'b0, penable_o}, dec ? 32'h0 : {31'b0, c >= 2});
        if (!dec) begin
          chk("paddr", paddr_o, addr);
          chk("pwrite", {31'b0, pwrite_o}, {31'b0, we});
          chk("pstrb", {28'b0, pstrb_o}, we ? {28'b0, be} : 32'h0);
          if (we) chk("pwdata", pwdata_o, wd);
        end
      end
      // slave behaviour for the next rising edge
      pready_i = NS'($urandom); pslverr_i = NS'($urandom);
      for (int j = 0; j < NS; j++)
        if (j != k) prdata_i[32*j +: 32] = $urandom;
      if (!dec) begin
        if (psel_o[k] && penable_o) acc++;
        pready_i[k]  = (acc > waits);
        if (acc > waits) pslverr_i[k] = serr;
      end
    end
  endtask

  // Transfer with expectations derived from the memory model, then model update.
  task automatic xfer(input int k, input int w, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, input int waits, input logic serr,
                      input logic cont, input logic keep, input string tag);
    logic [31:0] addr, exp_rd, rd, tmp;
    logic        exp_er, er, got;
    int          exp_lat, lat;
    addr    = 32'h8000_0000 | (32'(k) << LSB) | (32'(w) << 2);
    exp_lat = (k >= NS) ? 1 : 3 + waits;
    exp_er  = (k >= NS) ? 1'b1 : serr;
    exp_rd  = ((k >= NS) || we) ? 32'h0 : mem[k][w];
    do_txn(addr, we, be, wd, waits, serr, cont, keep, 200, got, lat, rd, er);
    chk({tag, "_got"}, {31'b0, got}, 32'h1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
    if ((k < NS) && we) begin
      tmp = mem[k][w];
      for (int b = 0; b < 4; b++)
        if (be[b]) tmp[8*b +: 8] = wd[8*b +: 8];
      mem[k][w] = tmp;
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk_i); #2;
    arstn_i = 1'b0;
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
  endtask

  initial begin
    logic        got, er;
    logic [31:0] rd;
    int          lat;
    arstn_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
    data_addr_i = '0; data_wdata_i = '0;
    prdata_i = '0; pready_i = '0; pslverr_i = '0;
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < 16; j++) mem[s][j] = $urandom;
    mem[0][1] = 32'h1234_5678;

    // reset state
    #12;
    chk("rst_psel", 32'(psel_o), 32'h0);
    chk("rst_penable", {31'b0, penable_o}, 32'h0);
    chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    chk("rst_rdata", data_rdata_o, 32'h0);
    chk("rst_err", {31'b0, data_err_o}, 32'h0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_gnt", {31'b0, data_gnt_o}, 32'h0);
    chk("rst_pstrb", {28'b0, pstrb_o}, 32'h0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;

    // directed: zero-wait read, waited write, decode error, slave error
    xfer(0, 1, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1'b0, "rd_s0");
    xfer(1, 2, 1'b1, 4'b0011, 32'h0000_CAFE, 3, 1'b0, 1'b0, 1'b0, "wr_s1");
    xfer(3, 0, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1'b0, "dec_err");
    xfer(1, 5, 1'b0, 4'hF, 32'h0, 1, 1'b1, 1'b0, 1'b0, "slverr");
    xfer(1, 2, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1'b0, "after_err");

    // back-to-back: request held through RESP is granted in the next IDLE cycle
    xfer(2, 7, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1'b1, "b2b_a");
    xfer(2, 7, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 1'b0, "b2b_b");

    // randomized traffic
    for (int n = 0; n < 40; n++)
      xfer($urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           4'($urandom), $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
           1'b0, 1'b0, "rnd");

    // asynchronous reset in the middle of ACCESS
    @(posedge clk_i); #1;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
    data_addr_i = 32'h8000_1010; pready_i = '0; pslverr_i = '0;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_penable", {31'b0, penable_o}, 32'h1);
    #1 arstn_i = 1'b0;
    #1;
    chk("arst_psel", 32'(psel_o), 32'h0);
    chk("arst_penable", {31'b0, penable_o}, 32'h0);
    chk("arst_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    data_req_i = 1'b0;
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_no_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    end
    xfer(0, 1, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1'b0, "post_rst_rd");

    // stuck slave
`ifdef MIRISCV_APB_TIMEOUT_EN
    do_txn(32'h8000_0008, 1'b0, 4'hF, 32'h0, 100000, 1'b0, 1'b0, 1'b0, 40, got, lat, rd, er);
    chk("to_got", {31'b0, got}, 32'h1);
    chk("to_err", {31'b0, er}, 32'h1);
    chk("to_rdata", rd, 32'hDEAD_BEEF);
    chk("to_lat_range", {31'b0, (lat >= 3) && (lat <= TO + 4)}, 32'h1);
    data_req_i = 1'b0;
`else
    do_txn(32'h8000_0008, 1'b0, 4'hF, 32'h0, 100000, 1'b0, 1'b0, 1'b0, 1000, got, lat, rd, er);
    chk("stuck_no_rvalid", {31'b0, got}, 32'h0);
    data_req_i = 1'b0;
    reset_pulse();
`endif
    xfer(0, 1, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1'b0, "after_stuck");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
